// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory pipeline stage:
// state encoding, timeout limit and flag bit positions.
package pipeline_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  localparam logic [3:0] TIMEOUT = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/flag_reg.sv
// Load-enabled 4-bit condition flag register.
// Synchronous active-high reset.
module flag_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 4'd0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: passes ALU results through, runs data-memory
// transactions with a bounded wait, and holds the flag register.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REGW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exValid,
  input  logic [WIDTH-1:0] aluOutput,
  input  logic [WIDTH-1:0] storeData,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             regWrite,
  input  logic             flagWrite,
  input  logic [REGW-1:0]  destReg,
  input  logic             N,
  input  logic             Z,
  input  logic             V,
  input  logic             C,
  input  logic             flush,
  output logic             stall,
  output logic             memReq,
  output logic             memWe,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] memWData,
  input  logic             memGnt,
  input  logic             memRValid,
  input  logic [WIDTH-1:0] memRData,
  output logic             wbValid,
  output logic             wbRegWrite,
  output logic [WIDTH-1:0] wbData,
  output logic [REGW-1:0]  wbDest,
  output logic [3:0]       flags,
  output logic             busErr
);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] laddr;
  logic [WIDTH-1:0] lwdata;
  logic             lwe;
  logic             lrw;
  logic [REGW-1:0]  ldest;
  logic             accept;
  logic             ismem;
  logic             expired;
  logic [3:0]       nzvc;

  assign accept  = (state == IDLE) && exValid && !flush;
  assign ismem   = memRead || memWrite;
  assign expired = (cnt == TIMEOUT - 4'd1);

  always_comb begin
    nzvc         = 4'd0;
    nzvc[FLAG_N] = N;
    nzvc[FLAG_Z] = Z;
    nzvc[FLAG_V] = V;
    nzvc[FLAG_C] = C;
  end

  flag_reg u_flags (
    .clk   (clk),
    .reset (reset),
    .load  (accept && flagWrite),
    .d     (nzvc),
    .q     (flags)
  );

  assign stall    = (state != IDLE);
  assign memReq   = (state == REQ);
  assign memWe    = memReq && lwe;
  assign memAddr  = laddr;
  assign memWData = lwdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      laddr      <= '0;
      lwdata     <= '0;
      lwe        <= 1'b0;
      lrw        <= 1'b0;
      ldest      <= '0;
      wbValid    <= 1'b0;
      wbRegWrite <= 1'b0;
      wbData     <= '0;
      wbDest     <= '0;
      busErr     <= 1'b0;
    end else begin
      wbValid <= 1'b0;
      busErr  <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (accept && ismem) begin
            laddr  <= aluOutput;
            lwdata <= storeData;
            lwe    <= memWrite && !memRead;
            lrw    <= regWrite;
            ldest  <= destReg;
            cnt    <= 4'd0;
            state  <= REQ;
          end else if (accept) begin
            wbValid    <= 1'b1;
            wbRegWrite <= regWrite;
            wbData     <= aluOutput;
            wbDest     <= destReg;
          end
        end
        (state == REQ): begin
          if (memGnt && lwe) begin
            wbValid    <= 1'b1;
            wbRegWrite <= 1'b0;
            wbDest     <= ldest;
            state      <= IDLE;
          end else if (memGnt) begin
            cnt   <= 4'd0;
            state <= WAIT_RD;
          end else if (expired) begin
            busErr <= 1'b1;
            cnt    <= 4'd0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        (state == WAIT_RD): begin
          if (memRValid) begin
            wbValid    <= 1'b1;
            wbRegWrite <= lrw;
            wbData     <= memRData;
            wbDest     <= ldest;
            state      <= IDLE;
          end else if (expired) begin
            busErr <= 1'b1;
            cnt    <= 4'd0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          cnt   <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with
// hand-computed expected values.
module tb_memory_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       exValid;
  logic [7:0] aluOutput;
  logic [7:0] storeData;
  logic       memRead, memWrite, regWrite, flagWrite;
  logic [3:0] destReg;
  logic       N, Z, V, C;
  logic       flush;
  logic       stall;
  logic       memReq, memWe;
  logic [7:0] memAddr, memWData;
  logic       memGnt, memRValid;
  logic [7:0] memRData;
  logic       wbValid, wbRegWrite;
  logic [7:0] wbData;
  logic [3:0] wbDest;
  logic [3:0] flags;
  logic       busErr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_stage #(.WIDTH(8), .REGW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .exValid    (exValid),
    .aluOutput  (aluOutput),
    .storeData  (storeData),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .regWrite   (regWrite),
    .flagWrite  (flagWrite),
    .destReg    (destReg),
    .N          (N),
    .Z          (Z),
    .V          (V),
    .C          (C),
    .flush      (flush),
    .stall      (stall),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memGnt     (memGnt),
    .memRValid  (memRValid),
    .memRData   (memRData),
    .wbValid    (wbValid),
    .wbRegWrite (wbRegWrite),
    .wbData     (wbData),
    .wbDest     (wbDest),
    .flags      (flags),
    .busErr     (busErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    exValid   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    flagWrite = 1'b0;
    flush     = 1'b0;
    {N, Z, V, C} = 4'b0000;
  endtask

  initial begin
    reset     = 1'b1;
    aluOutput = 8'h00;
    storeData = 8'h00;
    destReg   = 4'd0;
    memGnt    = 1'b0;
    memRValid = 1'b0;
    memRData  = 8'h00;
    idle_in();
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_memReq", memReq, 0);
    chk("rst_memWe", memWe, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWData", memWData, 0);
    chk("rst_wbValid", wbValid, 0);
    chk("rst_wbData", wbData, 0);
    chk("rst_wbDest", wbDest, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busErr", busErr, 0);
    reset = 1'b0;
    tick();

    // ALU op
    exValid = 1'b1; aluOutput = 8'h3C; destReg = 4'd5; regWrite = 1'b1;
    tick();
    chk("alu_wbValid", wbValid, 1);
    chk("alu_wbData", wbData, 8'h3C);
    chk("alu_wbDest", wbDest, 5);
    chk("alu_wbRegWrite", wbRegWrite, 1);
    chk("alu_stall", stall, 0);
    idle_in();
    tick();
    chk("alu_pulse", wbValid, 0);
    chk("alu_hold", wbData, 8'h3C);

    // back-to-back ALU ops
    exValid = 1'b1; regWrite = 1'b1; aluOutput = 8'h11; destReg = 4'd1;
    tick();
    chk("b2b_d1", wbData, 8'h11);
    chk("b2b_v1", wbValid, 1);
    aluOutput = 8'h22; destReg = 4'd2;
    tick();
    chk("b2b_d2", wbData, 8'h22);
    chk("b2b_v2", wbValid, 1);
    chk("b2b_dest2", wbDest, 2);
    idle_in();
    tick();

    // store, grant immediately
    exValid = 1'b1; memWrite = 1'b1; aluOutput = 8'h20;
    storeData = 8'h77; destReg = 4'd6; memGnt = 1'b1;
    tick();
    idle_in();
    chk("st_memReq", memReq, 1);
    chk("st_memWe", memWe, 1);
    chk("st_addr", memAddr, 8'h20);
    chk("st_wdata", memWData, 8'h77);
    chk("st_stall", stall, 1);
    chk("st_nowb", wbValid, 0);
    tick();
    memGnt = 1'b0;
    chk("st_wbValid", wbValid, 1);
    chk("st_wbRegWrite", wbRegWrite, 0);
    chk("st_memReq_off", memReq, 0);
    chk("st_memWe_off", memWe, 0);
    chk("st_stall_off", stall, 0);
    tick();
    chk("st_pulse", wbValid, 0);

    // load: grant after 2 cycles, data 3 cycles later
    exValid = 1'b1; memRead = 1'b1; regWrite = 1'b1;
    aluOutput = 8'h10; destReg = 4'd3;
    tick();
    idle_in();
    memRValid = 1'b1; memRData = 8'hEE;
    flush = 1'b1;
    chk("ld_memReq", memReq, 1);
    chk("ld_memWe", memWe, 0);
    chk("ld_addr", memAddr, 8'h10);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ld_req_stall", stall, 1);
      chk("ld_req_hold", memReq, 1);
      chk("ld_req_nowb", wbValid, 0);
    end
    memRValid = 1'b0; flush = 1'b0;
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    chk("ld_wait_memReq", memReq, 0);
    chk("ld_wait_stall", stall, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ld_wait_stall2", stall, 1);
      chk("ld_wait_nowb", wbValid, 0);
    end
    memRValid = 1'b1; memRData = 8'hA5;
    tick();
    memRValid = 1'b0;
    chk("ld_wbValid", wbValid, 1);
    chk("ld_wbData", wbData, 8'hA5);
    chk("ld_wbDest", wbDest, 3);
    chk("ld_wbRegWrite", wbRegWrite, 1);
    chk("ld_stall_off", stall, 0);
    tick();
    chk("ld_pulse", wbValid, 0);

    // load with no grant: timeout
    exValid = 1'b1; memRead = 1'b1; regWrite = 1'b1;
    aluOutput = 8'h40; destReg = 4'd7;
    tick();
    idle_in();
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_stall", stall, 1);
      chk("to_noerr", busErr, 0);
    end
    tick();
    chk("to_busErr", busErr, 1);
    chk("to_idle", stall, 0);
    chk("to_nowb", wbValid, 0);
    chk("to_memReq", memReq, 0);
    tick();
    chk("to_pulse", busErr, 0);

    // flags: load then flushed attempt
    exValid = 1'b1; flagWrite = 1'b1; {N, Z, V, C} = 4'b1010;
    aluOutput = 8'h01;
    tick();
    chk("fl_load", flags, 4'b1010);
    chk("fl_wb", wbValid, 1);
    flush = 1'b1; {N, Z, V, C} = 4'b0101;
    tick();
    chk("fl_flush_hold", flags, 4'b1010);
    chk("fl_flush_nowb", wbValid, 0);
    idle_in();
    tick();
    chk("fl_idle_hold", flags, 4'b1010);

    // reset during WAIT_RD
    exValid = 1'b1; memRead = 1'b1; regWrite = 1'b1;
    aluOutput = 8'h55; destReg = 4'd9;
    tick();
    idle_in();
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    chk("rw_in_wait", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_memReq", memReq, 0);
    chk("rw_stall", stall, 0);
    chk("rw_wbValid", wbValid, 0);
    chk("rw_flags", flags, 0);
    memRValid = 1'b1; memRData = 8'h99;
    tick();
    memRValid = 1'b0;
    chk("rw_late_rvalid", wbValid, 0);
    chk("rw_late_data", wbData, 0);
    chk("rw_late_stall", stall, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
